// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants: register-file geometry and functional-unit latencies.
package cpu_pkg;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned LAT_W     = 3;
  localparam int unsigned FLUSH_AGE = 2;
  localparam int unsigned LAT_ALU   = 1;
  localparam int unsigned LAT_LOAD  = 2;
  localparam int unsigned LAT_MUL   = 4;
endpackage

// File: rtl/scoreboard_entry.sv
// One register's scoreboard slot: pending flag, cycles remaining until forwardable, and age.
module scoreboard_entry #(
  parameter int unsigned LAT_W     = cpu_pkg::LAT_W,
  parameter int unsigned FLUSH_AGE = cpu_pkg::FLUSH_AGE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_i,
  input  logic [LAT_W-1:0] lat_i,
  input  logic             flush_i,
  output logic             pending_o,
  output logic [LAT_W-1:0] rem_o,
  output logic             pending_nxt_o
);
  localparam logic [LAT_W-1:0] MAX_LAT   = '1;
  localparam logic [LAT_W:0]   FLUSH_LIM = (LAT_W+1)'(FLUSH_AGE);

  logic [LAT_W-1:0] age, age_nxt, rem_nxt;
  logic             young;

  always_comb begin
    pending_nxt_o = pending_o;
    rem_nxt       = rem_o;
    age_nxt       = age;
    young         = ({1'b0, age} < FLUSH_LIM);
    if (set_i) begin
      pending_nxt_o = 1'b1;
      rem_nxt       = lat_i;
      age_nxt       = '0;
    end else if (pending_o) begin
      if (flush_i && young) begin
        pending_nxt_o = 1'b0;
        rem_nxt       = '0;
        age_nxt       = '0;
      end else begin
        // Expiry and a flush of an old entry share this path, so both just retire cleanly.
        rem_nxt = rem_o - 1'b1;
        age_nxt = (age == MAX_LAT) ? age : age + 1'b1;
        if (rem_nxt == '0) begin
          pending_nxt_o = 1'b0;
          age_nxt       = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_o <= 1'b0;
      rem_o     <= '0;
      age       <= '0;
    end else begin
      pending_o <= pending_nxt_o;
      rem_o     <= rem_nxt;
      age       <= age_nxt;
    end
  end
endmodule

// File: rtl/scoreboard_hu.sv
// Scoreboard-based stall path of the hazard unit: RAW/WAW checks, issue acceptance, busy count.
module scoreboard_hu #(
  parameter int unsigned ADDR_W    = cpu_pkg::ADDR_W,
  parameter int unsigned LAT_W     = cpu_pkg::LAT_W,
  parameter int unsigned FLUSH_AGE = cpu_pkg::FLUSH_AGE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_src0_i,
  input  logic [ADDR_W-1:0] issue_src1_i,
  input  logic              issue_src0_used_i,
  input  logic              issue_src1_used_i,
  input  logic [ADDR_W-1:0] issue_dst_i,
  input  logic              issue_we_i,
  input  logic [LAT_W-1:0]  issue_lat_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              issue_fire_o,
  output logic [ADDR_W:0]   busy_cnt_o
);
  localparam int unsigned NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] pend, pend_nxt;
  logic [LAT_W-1:0]    rem [NUM_REGS];
  logic [LAT_W-1:0]    lat_eff;
  logic                raw0, raw1, waw, record;
  logic [ADDR_W:0]     cnt_nxt;

  assign pend[0]     = 1'b0;
  assign pend_nxt[0] = 1'b0;
  assign rem[0]      = '0;

  assign lat_eff = (issue_lat_i == '0) ? LAT_W'(1) : issue_lat_i;

  // rem==1 means the producer sits on the forwarding path, so a reader may already issue.
  assign raw0 = issue_src0_used_i && pend[issue_src0_i] && (rem[issue_src0_i] > LAT_W'(1));
  assign raw1 = issue_src1_used_i && pend[issue_src1_i] && (rem[issue_src1_i] > LAT_W'(1));
  assign waw  = issue_we_i && pend[issue_dst_i] && (rem[issue_dst_i] > lat_eff);

  assign stall_o      = issue_valid_i && !flush_i && (raw0 || raw1 || waw);
  assign issue_fire_o = issue_valid_i && !stall_o && !flush_i;
  assign record       = issue_fire_o && issue_we_i && (issue_dst_i != '0);

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    scoreboard_entry #(
      .LAT_W     (LAT_W),
      .FLUSH_AGE (FLUSH_AGE)
    ) u_entry (
      .clk           (clk),
      .reset         (reset),
      .set_i         (record && (issue_dst_i == ADDR_W'(i))),
      .lat_i         (lat_eff),
      .flush_i       (flush_i),
      .pending_o     (pend[i]),
      .rem_o         (rem[i]),
      .pending_nxt_o (pend_nxt[i])
    );
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt_o <= '0;
    end else begin
      busy_cnt_o <= cnt_nxt;
    end
  end
endmodule
